wb_cmd_master: RTL and testbench

//   Wishbone B4 pipelined initiator: turns one valid/ready command into a single
//   cyc/stb transaction toward peripherals such as the LED and GPIO slaves.

---
 rtl/wb_master_pkg.sv | 21 ++
 rtl/wb_if.sv | 32 +++
 rtl/wb_cmd_master.sv | 139 +++++++++++++
 tb/tb_wb_cmd_master.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM states,
// default bus widths and the latched response bundle.
package wb_master_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    typedef struct packed {
        logic [WB_DW-1:0] dat;
        logic             err;
        logic             timeout;
    } rsp_t;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle carrying its own clock and
// synchronous active-high reset.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic clk,
    input logic rst
);

    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_m;
    logic [DW-1:0]   dat_s;
    logic            ack;
    logic            err;
    logic            stall;

    modport master (
        input  clk, rst, dat_s, ack, err, stall,
        output cyc, stb, we, adr, sel, dat_m
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, err, stall
    );

endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined initiator driven by a
// valid/ready command port, with a response port and bus timeout.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    wb_if.master            wb,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [DW-1:0]   cmd_dat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state, state_n;
    logic            cyc_q, cyc_n;
    logic            stb_q, stb_n;
    logic            we_q, we_n;
    logic [AW-1:0]   adr_q, adr_n;
    logic [DW/8-1:0] sel_q, sel_n;
    logic [DW-1:0]   dat_q, dat_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    rsp_t            rsp_q, rsp_n;
    logic            hit;
    logic            fire;

    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            state <= IDLE;
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
            rsp_q <= '0;
        end else begin
            state <= state_n;
            cyc_q <= cyc_n;
            stb_q <= stb_n;
            we_q  <= we_n;
            adr_q <= adr_n;
            sel_q <= sel_n;
            dat_q <= dat_n;
            cnt_q <= cnt_n;
            rsp_q <= rsp_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc_q;
        stb_n   = stb_q;
        we_n    = we_q;
        adr_n   = adr_q;
        sel_n   = sel_q;
        dat_n   = dat_q;
        cnt_n   = cnt_q;
        rsp_n   = rsp_q;
        hit     = 1'b0;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = REQ;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = cmd_we;
                    adr_n   = cmd_adr;
                    sel_n   = cmd_sel;
                    dat_n   = cmd_dat;
                    cnt_n   = '0;
                    rsp_n   = '0;
                end
            end
            REQ, WAIT: begin
                // A response during a stalled request has not been accepted yet
                hit  = (wb.ack || wb.err) && (state == WAIT || !wb.stall);
                fire = (TIMEOUT != 0) && (cnt_q == TLAST) && !hit;
                if (hit) begin
                    state_n       = RSP;
                    cyc_n         = 1'b0;
                    stb_n         = 1'b0;
                    rsp_n.err     = wb.err;
                    rsp_n.timeout = 1'b0;
                    rsp_n.dat     = (wb.err || we_q) ? '0 : WB_DW'(wb.dat_s);
                end else if (fire) begin
                    state_n       = RSP;
                    cyc_n         = 1'b0;
                    stb_n         = 1'b0;
                    rsp_n.err     = 1'b1;
                    rsp_n.timeout = 1'b1;
                    rsp_n.dat     = '0;
                end else begin
                    if (state == REQ && !wb.stall) begin
                        state_n = WAIT;
                        stb_n   = 1'b0;
                    end
                    if (cnt_q != '1) begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.adr   = adr_q;
    assign wb.sel   = sel_q;
    assign wb.dat_m = dat_q;

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RSP);
    assign rsp_dat     = DW'(rsp_q.dat);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: behavioural slave (LED register, stall,
// err, silent) plus a transaction-level reference model.
module tb_wb_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    wb_if #(.AW(32), .DW(32)) bus (.clk(clk), .rst(rst));

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .wb(bus),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_adr(cmd_adr),
        .cmd_sel(cmd_sel),
        .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
        end
    endtask

    // slave: mode 0 ack, 1 err, 2 ack+err, 3 silent
    logic [31:0] smem [16];
    logic [3:0]  led;
    int          s_mode = 0;
    int          s_stall = 0;
    int          stall_left = 0;
    int          accepts = 0;
    int          stb_cnt = 0;
    logic        force_ack = 1'b0;
    logic        pend = 1'b0;
    int          p_mode = 0;
    logic        p_we = 1'b0;
    logic [3:0]  p_idx = '0;

    assign led = smem[0][3:0];

    initial begin
        for (int i = 0; i < 16; i++) smem[i] = '0;
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.stall = 1'b0;
        bus.dat_s = '0;
    end

    always @(posedge clk) begin
        #1;
        bus.ack = force_ack;
        bus.err = 1'b0;
        bus.stall = 1'b0;
        bus.dat_s = 32'hDEAD_BEEF;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                case (p_mode)
                    0: begin
                        bus.ack = 1'b1;
                        if (!p_we) bus.dat_s = smem[p_idx];
                    end
                    1: bus.err = 1'b1;
                    2: begin
                        bus.ack = 1'b1;
                        bus.err = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (bus.cyc && bus.stb) begin
                if (stall_left > 0) begin
                    bus.stall = 1'b1;
                    stall_left--;
                end else begin
                    pend = 1'b1;
                    p_mode = s_mode;
                    p_we = bus.we;
                    p_idx = bus.adr[5:2];
                    accepts++;
                    if (bus.we && s_mode == 0) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.sel[b]) smem[p_idx][b*8 +: 8] = bus.dat_m[b*8 +: 8];
                    end
                end
            end
        end
    end

    // reference model: one transaction in flight, timing from the cycle rules
    logic        chk_en = 1'b0;
    logic        busy = 1'b0;
    int          hs = 0;
    int          due = 0;
    int          m_stall = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_wdat = '0;
    logic [31:0] e_dat = '0;
    logic        e_err = 1'b0;
    logic        e_to = 1'b0;
    logic [31:0] mmem [16];

    initial for (int i = 0; i < 16; i++) mmem[i] = '0;

    always @(negedge clk) begin : model
        int   c;
        logic exp_rv;
        logic exp_cyc;
        logic exp_stb;
        if (chk_en) begin
            c = cyc_cnt;
            exp_rv  = busy && (c >= due);
            exp_cyc = busy && (c > hs) && (c < due);
            exp_stb = busy && (c > hs) && (c <= hs + 1 + m_stall);
            if (bus.stb) stb_cnt++;
            chk("cmd_ready", cmd_ready, !busy);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("cyc", bus.cyc, exp_cyc);
            chk("stb", bus.stb, exp_stb);
            if (exp_stb) begin
                chk("adr", bus.adr, m_adr);
                chk("we", bus.we, m_we);
                chk("sel", bus.sel, m_sel);
                chk("dat_o", bus.dat_m, m_wdat);
            end
            if (exp_rv) begin
                chk("rsp_dat", rsp_dat, e_dat);
                chk("rsp_err", rsp_err, e_err);
                chk("rsp_timeout", rsp_timeout, e_to);
            end
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (exp_rv && rsp_ready) busy = 1'b0;
            end else if (cmd_valid) begin
                busy = 1'b1;
                hs = c;
                m_stall = s_stall;
                m_we = cmd_we;
                m_adr = cmd_adr;
                m_sel = cmd_sel;
                m_wdat = cmd_dat;
                e_dat = '0;
                e_err = 1'b1;
                e_to = 1'b0;
                due = c + 3 + s_stall;
                if (s_mode == 0) begin
                    e_err = 1'b0;
                    if (cmd_we) begin
                        for (int b = 0; b < 4; b++)
                            if (cmd_sel[b]) mmem[cmd_adr[5:2]][b*8 +: 8] = cmd_dat[b*8 +: 8];
                    end else begin
                        e_dat = mmem[cmd_adr[5:2]];
                    end
                end else if (s_mode == 3) begin
                    e_to = 1'b1;
                    due = c + TO + 1;
                end
            end
        end
    end

    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int md, input int st, input int hold,
                       output logic [31:0] rd, output logic re, output logic rt,
                       output int lat);
        int h;
        int n;
        @(posedge clk); #2;
        s_mode = md;
        s_stall = st;
        stall_left = st;
        stb_cnt = 0;
        accepts = 0;
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_adr = a;
        cmd_dat = d;
        cmd_sel = s;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        h = cyc_cnt;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        lat = cyc_cnt - h;
        if (!rsp_valid) begin
            failures++;
            $display("FAIL rsp_wait: no response within 40 cycles");
        end
        n = 0;
        repeat (hold) begin
            @(posedge clk); #2;
            if (cmd_ready) n++;
        end
        if (hold > 0) chk("hold_cmd_ready", n, 0);
        rsp_ready = 1'b1;
        rd = rsp_dat;
        re = rsp_err;
        rt = rsp_timeout;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        re;
        logic        rt;
        int          lat;
        int          nrv;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_dat_o", bus.dat_m, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        chk_en = 1'b1;

        run(1'b1, 32'h0, 32'h0000_000A, 4'hF, 0, 0, 0, rd, re, rt, lat);
        chk("wr_lat", lat, 3);
        chk("wr_err", re, 0);
        chk("wr_stb_cycles", stb_cnt, 1);
        chk("led", led, 4'hA);

        run(1'b0, 32'h0, 32'h0, 4'hF, 0, 0, 0, rd, re, rt, lat);
        chk("rd_dat", rd, 32'h0000_000A);
        chk("rd_err", re, 0);
        chk("rd_lat", lat, 3);

        run(1'b1, 32'h4, 32'h1234_5678, 4'hF, 0, 3, 0, rd, re, rt, lat);
        chk("stall_stb_cycles", stb_cnt, 4);
        chk("stall_accepts", accepts, 1);
        chk("stall_lat", lat, 6);

        run(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 5, rd, re, rt, lat);
        chk("hold_rd_dat", rd, 32'h1234_5678);

        run(1'b0, 32'h8, 32'h0, 4'hF, 3, 0, 0, rd, re, rt, lat);
        chk("to_lat", lat, TO + 1);
        chk("to_err", re, 1);
        chk("to_timeout", rt, 1);
        chk("to_dat", rd, 0);
        force_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("late_ack_rsp_valid", rsp_valid, 0);
        chk("late_ack_cyc", bus.cyc, 0);

        run(1'b0, 32'h0, 32'h0, 4'hF, 2, 0, 0, rd, re, rt, lat);
        chk("both_err", re, 1);
        chk("both_timeout", rt, 0);
        chk("both_dat", rd, 0);

        run(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, 1, 1, 0, rd, re, rt, lat);
        chk("err_wr_err", re, 1);
        chk("err_wr_dat", rd, 0);
        chk("err_wr_lat", lat, 4);

        @(posedge clk); #2;
        s_mode = 3;
        s_stall = 0;
        stall_left = 0;
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_adr = 32'h10;
        cmd_sel = 4'hF;
        cmd_dat = '0;
        chk("rst_test_ready", cmd_ready, 1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_test_cyc_before", bus.cyc, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst_mid_cyc", bus.cyc, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        nrv = 0;
        repeat (12) begin
            @(posedge clk); #2;
            if (rsp_valid) nrv++;
        end
        chk("rst_mid_no_rsp", nrv, 0);

        run(1'b1, 32'h0, 32'hFFFF_5555, 4'b0011, 0, 0, 0, rd, re, rt, lat);
        chk("part_wr_err", re, 0);
        run(1'b0, 32'h0, 32'h0, 4'hF, 0, 0, 0, rd, re, rt, lat);
        chk("part_rd_dat", rd, 32'h0000_5555);

        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
